alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters using a round-robin
// grant and a three-state FSM (IDLE -> EXEC -> RESP -> IDLE).
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where both valid and ready are high. A requester may raise or drop
// valid at any time while it is not granted. The arbiter raises reqN_ready
// only in IDLE and only for the requester it grants. It holds respN_valid
// high with a stable respN_result until respN_ready is seen for that requester.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   req{0,1}_valid/_ready            request handshake
//   req{0,1}_a/_b/_op                request operands and opcode
//   resp{0,1}_valid/_ready/_result   response channel
//   alu_a, alu_b, alu_op             drive the shared ALU from latched registers
//   alu_result                       combinational ALU output
//   busy                             high whenever the FSM is not in IDLE
//   dbg_state                        current FSM state encoding (0 IDLE, 1 EXEC, 2 RESP)
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     resp0_valid,
    input  logic                     resp0_ready,
    output logic [DATA_WIDTH-1:0]    resp0_result,
    output logic                     resp1_valid,
    input  logic                     resp1_ready,
    output logic [DATA_WIDTH-1:0]    resp1_result,
    output logic [DATA_WIDTH-1:0]    alu_a,
    output logic [DATA_WIDTH-1:0]    alu_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [DATA_WIDTH-1:0]    a_q;
    logic [DATA_WIDTH-1:0]    b_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic                     gnt_q;       // requester being served
    logic                     last_grant;  // requester served most recently

    logic                     any_valid;
    logic                     grant_id;
    logic                     accept;
    logic                     resp_done;

    // Round-robin pick: a lone requester always wins; on a tie the requester
    // that was not served last time wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_comb begin
        state_nx    = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        accept      = 1'b0;
        resp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nx   = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                resp0_valid = ~gnt_q;
                resp1_valid = gnt_q;
                // Only the served requester's ready can close the response.
                resp_done   = gnt_q ? resp1_ready : resp0_ready;
                if (resp_done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q        <= grant_id ? req1_a  : req0_a;
                b_q        <= grant_id ? req1_b  : req0_b;
                op_q       <= grant_id ? req1_op : req0_op;
                gnt_q      <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    // The ALU only ever sees latched operands, so requesters may change
    // their inputs freely once accepted.
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single transactions with
// hand-computed grants and results, followed by hand-written sequences for
// fairness, back-pressure, mid-operation reset and operand isolation.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk;
    logic          reset;
    logic          req0_valid, req0_ready;
    logic [DW-1:0] req0_a, req0_b;
    logic [OW-1:0] req0_op;
    logic          req1_valid, req1_ready;
    logic [DW-1:0] req1_a, req1_b;
    logic [OW-1:0] req1_op;
    logic          resp0_valid, resp0_ready;
    logic [DW-1:0] resp0_result;
    logic          resp1_valid, resp1_ready;
    logic [DW-1:0] resp1_result;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_op;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_cmp;
    int n_err;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Shared ALU: 0 AND, 1 OR, 2 ADD, 3 SUB, anything else XOR.
    always_comb begin
        case (alu_op)
            4'h0:    alu_result = alu_a & alu_b;
            4'h1:    alu_result = alu_a | alu_b;
            4'h2:    alu_result = alu_a + alu_b;
            4'h3:    alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        bit            do_reset;
        bit            v0;
        logic [DW-1:0] a0, b0;
        logic [OW-1:0] op0;
        bit            v1;
        logic [DW-1:0] a1, b1;
        logic [OW-1:0] op1;
        bit            exp_g;
        logic [DW-1:0] exp_res;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_rv0", resp0_valid, 0);
        chk("rst_rv1", resp1_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_res", resp0_result, 0);
        reset = 1'b0;
    endtask

    // One complete transaction starting from IDLE, #1 after a clock edge.
    task automatic run_vec(input vec_t v, input int idx);
        logic [DW-1:0] exp_a;
        exp_a = v.exp_g ? v.a1 : v.a0;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_rdy0", idx), req0_ready, !v.exp_g);
        chk($sformatf("v%0d_rdy1", idx), req1_ready, v.exp_g);
        chk($sformatf("v%0d_idle_busy", idx), busy, 0);
        tick();                                   // accept edge -> EXEC
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_exec_busy", idx), busy, 1);
        chk($sformatf("v%0d_exec_rdy", idx), {req0_ready, req1_ready}, 0);
        chk($sformatf("v%0d_exec_rv", idx), {resp0_valid, resp1_valid}, 0);
        chk($sformatf("v%0d_alu_a", idx), alu_a, exp_a);
        tick();                                   // capture edge -> RESP
        chk($sformatf("v%0d_rv0", idx), resp0_valid, !v.exp_g);
        chk($sformatf("v%0d_rv1", idx), resp1_valid, v.exp_g);
        chk($sformatf("v%0d_res", idx), v.exp_g ? resp1_result : resp0_result, v.exp_res);
        tick();                                   // response taken -> IDLE
        chk($sformatf("v%0d_back_idle", idx), busy, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        //          rst v0 a0            b0            op0   v1 a1            b1            op1   g  result
        vecs[0] = '{1, 1, 32'd5,        32'd3,        4'h2, 0, 32'd0,        32'd0,        4'h0, 0, 32'd8};
        vecs[1] = '{1, 1, 32'd10,       32'd4,        4'h3, 1, 32'hF0,       32'h3C,       4'h0, 0, 32'd6};
        vecs[2] = '{0, 1, 32'd10,       32'd4,        4'h3, 1, 32'hF0,       32'h3C,       4'h0, 1, 32'h30};
        vecs[3] = '{0, 0, 32'd0,        32'd0,        4'h0, 1, 32'h0F,       32'hF0,       4'h1, 1, 32'hFF};
        vecs[4] = '{0, 1, 32'hAA,       32'h55,       4'h4, 1, 32'd1,        32'd1,        4'h2, 0, 32'hFF};
        vecs[5] = '{0, 1, 32'd1,        32'd1,        4'h2, 1, 32'hFFFFFFFF, 32'd1,        4'h2, 1, 32'h0};
        vecs[6] = '{0, 1, 32'd0,        32'd1,        4'h3, 0, 32'd0,        32'd0,        4'h0, 0, 32'hFFFFFFFF};
        vecs[7] = '{0, 1, 32'd3,        32'd3,        4'h2, 1, 32'h12345678, 32'hFFFFFFFF, 4'hF, 1, 32'hEDCBA987};
        vecs[8] = '{0, 1, 32'h80000000, 32'h80000000, 4'h2, 0, 32'd0,        32'd0,        4'h0, 0, 32'h0};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_reset) do_reset();
            run_vec(vecs[i], i);
        end

        // Fairness: both requesters valid throughout, grants must alternate.
        do_reset();
        req0_a = 32'd1; req0_b = 32'd0; req0_op = 4'h2;
        req1_a = 32'd2; req1_b = 32'd0; req1_op = 4'h2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk($sformatf("fair%0d_rdy0", g), req0_ready, (g % 2) == 0);
            chk($sformatf("fair%0d_rdy1", g), req1_ready, (g % 2) == 1);
            tick();
            chk($sformatf("fair%0d_exec_rdy", g), {req0_ready, req1_ready}, 0);
            tick();
            chk($sformatf("fair%0d_res", g), (g % 2) ? resp1_result : resp0_result,
                (g % 2) ? 32'd2 : 32'd1);
            chk($sformatf("fair%0d_rv", g), {resp1_valid, resp0_valid}, (g % 2) ? 2 : 1);
            tick();
        end
        idle_inputs();

        // Back-pressure on requester 1; req0 waits and resp0_ready is ignored.
        #1;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd9; req1_op = 4'h2;
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd1; req0_op = 4'h3;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_rv1", c), resp1_valid, 1);
            chk($sformatf("bp%0d_res", c), resp1_result, 32'd16);
            chk($sformatf("bp%0d_rdy0", c), req0_ready, 0);
            chk($sformatf("bp%0d_busy", c), busy, 1);
            chk($sformatf("bp%0d_rv0", c), resp0_valid, 0);
            tick();
        end
        resp1_ready = 1'b1;
        tick();
        chk("bp_release_idle", busy, 0);
        chk("bp_rdy0_after", req0_ready, 1);
        chk("bp_retain_res", resp1_result, 32'd16);
        req0_valid = 1'b0;
        #1;

        // Reset during EXEC aborts the operation.
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'h2;
        tick();
        req1_valid = 1'b0;
        chk("mr_in_exec", dbg_state, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_state", dbg_state, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rv", {resp0_valid, resp1_valid}, 0);
        chk("mr_alu_a", alu_a, 0);
        chk("mr_res", resp1_result, 0);
        tick();
        chk("mr_still_no_rv", {resp0_valid, resp1_valid, busy}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_tie_rdy0", req0_ready, 1);
        chk("mr_tie_rdy1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Operand isolation: requester changes req0_a after acceptance.
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 4'h3;
        tick();
        req0_a = 32'hDEAD;
        req0_valid = 1'b0;
        #1;
        chk("iso_alu_a", alu_a, 32'd100);
        tick();
        chk("iso_res", resp0_result, 32'd99);
        chk("iso_rv0", resp0_valid, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Absolute run bound so the bench always ends.
    initial begin
        #50000;
        $display("FAIL timeout: run did not complete, got no summary expected summary");
        $fatal(1, "timeout");
    end

endmodule
